// File: rtl/ldtu_word_decoder.sv
// LiTe-DTU output-word decoder: unpacks 32-bit encoded words into 13-bit samples and checks headers.
// Optional frame-trailer count check is enabled by defining LDTU_DEC_FRAMECHK_EN.
module ldtu_word_decoder #(
  parameter int Nbits_12   = 12,
  parameter int NBitsFrame = 8,
  parameter int NBitsErr   = 8
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic [31:0]         word_in,
  input  logic                word_valid,
  output logic                word_ready,
  output logic [Nbits_12:0]   sample_out,
  output logic                sample_bsl,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                frame_end,
  output logic                frame_err,
  output logic                hdr_err,
  output logic [NBitsErr-1:0] err_cnt
);

  localparam int SW = Nbits_12 + 1;

  logic [29:0]         hold_q, hold_d;
  logic [2:0]          pend_q, pend_d;
  logic [2:0]          idx_q, idx_d;
  logic                bsl_q, bsl_d;
  logic                frame_end_q, frame_end_d;
  logic                frame_err_q, frame_err_d;
  logic                hdr_err_q, hdr_err_d;
  logic [NBitsErr-1:0] err_cnt_q, err_cnt_d;

  logic is_bsl, is_sig2, is_sig1, is_trl, is_idle, is_ill;
  logic word_acc, samp_acc;
  logic [SW-1:0] samp_raw;

  assign sample_valid = (pend_q != 3'd0);
  assign word_ready   = (pend_q == 3'd0) || ((pend_q == 3'd1) && sample_ready);
  assign word_acc     = word_valid && word_ready;
  assign samp_acc     = sample_valid && sample_ready;

  always_comb begin
    is_bsl  = (word_in[31:30] == 2'b01);
    is_sig2 = (word_in[31:26] == 6'b001010);
    is_sig1 = (word_in[31:26] == 6'b001011);
    is_trl  = (word_in[31:28] == 4'b1101);
    is_idle = (word_in[31:28] == 4'b1110);
    is_ill  = !(is_bsl || is_sig2 || is_sig1 || is_trl || is_idle);
  end

  // A new word may replace the last pending sample in the same cycle it is consumed.
  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    idx_d  = idx_q;
    bsl_d  = bsl_q;
    if (word_acc) begin
      hold_d = word_in[29:0];
      idx_d  = 3'd0;
      bsl_d  = is_bsl;
      if (is_bsl)       pend_d = 3'd5;
      else if (is_sig2) pend_d = 3'd2;
      else if (is_sig1) pend_d = 3'd1;
      else              pend_d = 3'd0;
    end else if (samp_acc) begin
      pend_d = pend_q - 3'd1;
      idx_d  = idx_q + 3'd1;
    end
  end

  always_comb begin
    samp_raw = '0;
    if (bsl_q) begin
      case (idx_q)
        3'd0:    samp_raw = {{(SW-6){1'b0}}, hold_q[5:0]};
        3'd1:    samp_raw = {{(SW-6){1'b0}}, hold_q[11:6]};
        3'd2:    samp_raw = {{(SW-6){1'b0}}, hold_q[17:12]};
        3'd3:    samp_raw = {{(SW-6){1'b0}}, hold_q[23:18]};
        3'd4:    samp_raw = {{(SW-6){1'b0}}, hold_q[29:24]};
        default: samp_raw = '0;
      endcase
    end else if (idx_q == 3'd0) begin
      samp_raw = hold_q[SW-1:0];
    end else begin
      samp_raw = hold_q[2*SW-1:SW];
    end
  end

  assign sample_out = sample_valid ? samp_raw : '0;
  assign sample_bsl = sample_valid && bsl_q;

`ifdef LDTU_DEC_FRAMECHK_EN
  logic [NBitsFrame-1:0] cnt_q, cnt_d, cnt_inc;

  // The trailer compares against a count that already includes a same-cycle sample.
  always_comb begin
    cnt_inc     = (samp_acc && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    frame_err_d = word_acc && is_trl && (NBitsFrame'(word_in[27:20]) != cnt_inc);
    cnt_d       = (word_acc && is_trl) ? '0 : cnt_inc;
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  always_comb begin
    frame_err_d = 1'b0;
  end
`endif

  always_comb begin
    frame_end_d = word_acc && is_trl;
    hdr_err_d   = word_acc && is_ill;
    err_cnt_d   = err_cnt_q;
    if ((hdr_err_d || frame_err_d) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      hold_q      <= '0;
      pend_q      <= 3'd0;
      idx_q       <= 3'd0;
      bsl_q       <= 1'b0;
      frame_end_q <= 1'b0;
      frame_err_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      bsl_q       <= bsl_d;
      frame_end_q <= frame_end_d;
      frame_err_q <= frame_err_d;
      hdr_err_q   <= hdr_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_end = frame_end_q;
  assign frame_err = frame_err_q;
  assign hdr_err   = hdr_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ldtu_word_decoder.sv
// Randomised bench for ldtu_word_decoder with a word-level reference model.
// Expectations follow LDTU_DEC_FRAMECHK_EN the same way as the design build.
module tb_ldtu_word_decoder;

`ifdef LDTU_DEC_FRAMECHK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        rst_b = 1'b0;
  logic [31:0] word_in = 32'h0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [12:0] sample_out;
  logic        sample_bsl;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        frame_end;
  logic        frame_err;
  logic        hdr_err;
  logic [7:0]  err_cnt;

  always #5 CLK = ~CLK;

  ldtu_word_decoder dut (
    .CLK(CLK), .rst_b(rst_b), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .sample_out(sample_out), .sample_bsl(sample_bsl),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .frame_end(frame_end),
    .frame_err(frame_err), .hdr_err(hdr_err), .err_cnt(err_cnt)
  );

  int n_total = 0;
  int n_bad = 0;

  logic [31:0] wq[$];
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  int exp_fe, exp_ferr, exp_herr;
  int obs_fe, obs_ferr, obs_herr, stall_viol;
  int m_frame, m_err;
  bit timeout;

  function automatic bit is_legal(input logic [31:0] w);
    return (w[31:30] == 2'b01) || (w[31:26] == 6'b001010) || (w[31:26] == 6'b001011) ||
           (w[31:28] == 4'hD) || (w[31:28] == 4'hE);
  endfunction

  task automatic clear_obs();
    wq.delete(); exp_q.delete(); obs_q.delete();
    exp_fe = 0; exp_ferr = 0; exp_herr = 0;
    obs_fe = 0; obs_ferr = 0; obs_herr = 0; stall_viol = 0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    word_valid = 1'b0; word_in = 32'h0; sample_ready = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(posedge CLK);
    #1 rst_b = 1'b1;
    m_frame = 0; m_err = 0;
    clear_obs();
  endtask

  // Reference model: what the decoder must produce for one accepted word.
  task automatic add_word(input logic [31:0] w);
    int n;
    wq.push_back(w);
    n = 0;
    if (w[31:30] == 2'b01) begin
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 7'b0, 6'(w >> (6 * i))});
      n = 5;
    end else if (w[31:26] == 6'b001010) begin
      exp_q.push_back({1'b0, 13'(w)});
      exp_q.push_back({1'b0, 13'(w >> 13)});
      n = 2;
    end else if (w[31:26] == 6'b001011) begin
      exp_q.push_back({1'b0, 13'(w)});
      n = 1;
    end else if (w[31:28] == 4'hD) begin
      exp_fe++;
      if (FCHK && (int'(w[27:20]) != m_frame)) begin
        exp_ferr++;
        if (m_err < 255) m_err++;
      end
      m_frame = 0;
    end else if (w[31:28] != 4'hE) begin
      exp_herr++;
      if (m_err < 255) m_err++;
    end
    m_frame = (m_frame + n > 255) ? 255 : m_frame + n;
  endtask

  // Drives queued words and records everything observed; no judgement here.
  task automatic run_words(input int ready_pct, input int max_cyc);
    int cyc;
    int idle;
    logic [13:0] prev;
    bit prev_stall;
    cyc = 0; idle = 0; prev = '0; prev_stall = 1'b0; timeout = 1'b0;
    forever begin
      word_valid = (wq.size() > 0);
      word_in = (wq.size() > 0) ? wq[0] : 32'h0;
      sample_ready = ($urandom_range(99) < ready_pct);
      #4;
      if (prev_stall && (!sample_valid || {sample_bsl, sample_out} !== prev)) stall_viol++;
      if (word_valid && word_ready) void'(wq.pop_front());
      if (sample_valid && sample_ready) obs_q.push_back({sample_bsl, sample_out});
      if (frame_end) obs_fe++;
      if (frame_err) obs_ferr++;
      if (hdr_err) obs_herr++;
      prev_stall = sample_valid && !sample_ready;
      prev = {sample_bsl, sample_out};
      if (wq.size() == 0 && !sample_valid) idle++;
      else idle = 0;
      cyc++;
      @(posedge CLK); #1;
      if (idle >= 3) break;
      if (cyc >= max_cyc) begin
        timeout = 1'b1;
        break;
      end
    end
    word_valid = 1'b0;
    sample_ready = 1'b0;
  endtask

  task automatic test_reset();
    word_valid = 1'b0; sample_ready = 1'b0; rst_b = 1'b0;
    #3;
    n_total++; if (sample_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid got=%0b exp=0", sample_valid); end
    n_total++; if (sample_out !== 13'h0) begin n_bad++; $display("[TB] FAIL rst_sample got=%0h exp=0", sample_out); end
    n_total++; if (sample_bsl !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_bsl got=%0b exp=0", sample_bsl); end
    n_total++; if ({frame_end, frame_err, hdr_err} !== 3'b000) begin n_bad++; $display("[TB] FAIL rst_pulses got=%0b exp=000", {frame_end, frame_err, hdr_err}); end
    n_total++; if (err_cnt !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_errcnt got=%0h exp=0", err_cnt); end
    @(posedge CLK); #1 rst_b = 1'b1;
    @(negedge CLK);
    n_total++; if (word_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_word_ready got=%0b exp=1", word_ready); end
    @(posedge CLK); #1;
  endtask

  task automatic test_baseline();
    logic [31:0] w;
    do_reset();
    w = 32'h4000_0000 | {2'b00, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
    word_valid = 1'b1; word_in = w; sample_ready = 1'b1;
    #4;
    n_total++; if (word_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL bsl_accept got=%0b exp=1", word_ready); end
    @(posedge CLK); #1 word_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #4;
      n_total++; if (sample_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL bsl_valid%0d got=%0b exp=1", k, sample_valid); end
      n_total++; if (sample_out !== 13'(k + 1)) begin n_bad++; $display("[TB] FAIL bsl_sample%0d got=%0h exp=%0h", k, sample_out, k + 1); end
      n_total++; if (sample_bsl !== 1'b1) begin n_bad++; $display("[TB] FAIL bsl_flag%0d got=%0b exp=1", k, sample_bsl); end
      n_total++; if (word_ready !== (k == 4)) begin n_bad++; $display("[TB] FAIL bsl_wready%0d got=%0b exp=%0b", k, word_ready, k == 4); end
      @(posedge CLK); #1;
    end
    #4;
    n_total++; if (sample_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL bsl_drain got=%0b exp=0", sample_valid); end
    @(posedge CLK); #1;
  endtask

  task automatic test_signal_stall();
    do_reset();
    word_valid = 1'b1; word_in = 32'h2800_0000 | {6'b0, 13'h1ABC, 13'h0123}; sample_ready = 1'b0;
    @(posedge CLK); #1 word_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      n_total++; if (sample_valid !== 1'b1 || sample_out !== 13'h0123) begin n_bad++; $display("[TB] FAIL sig_hold%0d got=%0b/%0h exp=1/123", k, sample_valid, sample_out); end
      n_total++; if (word_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL sig_wready%0d got=%0b exp=0", k, word_ready); end
      @(posedge CLK); #1;
    end
    sample_ready = 1'b1;
    #4;
    n_total++; if (sample_out !== 13'h0123 || sample_bsl !== 1'b0) begin n_bad++; $display("[TB] FAIL sig_s0 got=%0h/%0b exp=123/0", sample_out, sample_bsl); end
    @(posedge CLK); #4;
    n_total++; if (sample_valid !== 1'b1 || sample_out !== 13'h1ABC || sample_bsl !== 1'b0) begin n_bad++; $display("[TB] FAIL sig_s1 got=%0b/%0h/%0b exp=1/1abc/0", sample_valid, sample_out, sample_bsl); end
    @(posedge CLK); #4;
    n_total++; if (sample_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL sig_drain got=%0b exp=0", sample_valid); end
    @(posedge CLK); #1;
  endtask

  task automatic test_frames();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 5; i++) add_word(32'h2800_0000 | ($urandom() & 32'h03FF_FFFF));
      add_word((f == 0) ? 32'hD0A0_0000 : 32'hD0B0_0000);
    end
    run_words(100, 200);
    n_total++; if (timeout !== 1'b0) begin n_bad++; $display("[TB] FAIL frm_timeout got=%0b exp=0", timeout); end
    n_total++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL frm_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL frm_sample%0d got=%0h exp=%0h", i, obs_q[i], exp_q[i]); end
    end
    n_total++; if (obs_fe != 2) begin n_bad++; $display("[TB] FAIL frm_end got=%0d exp=2", obs_fe); end
    n_total++; if (obs_ferr != (FCHK ? 1 : 0)) begin n_bad++; $display("[TB] FAIL frm_err got=%0d exp=%0d", obs_ferr, FCHK ? 1 : 0); end
    n_total++; if (err_cnt !== (FCHK ? 8'd1 : 8'd0)) begin n_bad++; $display("[TB] FAIL frm_errcnt got=%0d exp=%0d", err_cnt, FCHK ? 1 : 0); end
  endtask

  task automatic test_illegal_idle();
    do_reset();
    add_word(32'hF000_0000);
    run_words(100, 50);
    n_total++; if (obs_q.size() != 0) begin n_bad++; $display("[TB] FAIL ill_samples got=%0d exp=0", obs_q.size()); end
    n_total++; if (obs_herr != 1) begin n_bad++; $display("[TB] FAIL ill_hdr got=%0d exp=1", obs_herr); end
    n_total++; if (err_cnt !== 8'd1) begin n_bad++; $display("[TB] FAIL ill_errcnt got=%0d exp=1", err_cnt); end
    clear_obs();
    add_word(32'hE000_0000);
    run_words(100, 50);
    n_total++; if (obs_q.size() != 0 || obs_herr != 0 || obs_fe != 0) begin n_bad++; $display("[TB] FAIL idle_effect got=%0d/%0d/%0d exp=0/0/0", obs_q.size(), obs_herr, obs_fe); end
    n_total++; if (err_cnt !== 8'd1) begin n_bad++; $display("[TB] FAIL idle_errcnt got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    word_valid = 1'b1; word_in = 32'h4000_0000 | {2'b00, 6'd55, 6'd44, 6'd33, 6'd22, 6'd11}; sample_ready = 1'b1;
    @(posedge CLK); #1 word_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #2 rst_b = 1'b0;
    #1;
    n_total++; if (sample_valid !== 1'b0 || sample_out !== 13'h0) begin n_bad++; $display("[TB] FAIL mid_rst got=%0b/%0h exp=0/0", sample_valid, sample_out); end
    @(posedge CLK); #1 rst_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #4;
      n_total++; if (sample_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_residual%0d got=%0b exp=0", k, sample_valid); end
      @(posedge CLK); #1;
    end
    #4;
    n_total++; if (word_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_wready got=%0b exp=1", word_ready); end
    @(posedge CLK); #1;
  endtask

  task automatic test_err_saturate();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      do w = $urandom(); while (is_legal(w));
      add_word(w);
    end
    run_words(100, 600);
    n_total++; if (timeout !== 1'b0) begin n_bad++; $display("[TB] FAIL sat_timeout got=%0b exp=0", timeout); end
    n_total++; if (obs_herr != 260) begin n_bad++; $display("[TB] FAIL sat_hdr got=%0d exp=260", obs_herr); end
    n_total++; if (err_cnt !== 8'hFF) begin n_bad++; $display("[TB] FAIL sat_errcnt got=%0h exp=ff", err_cnt); end
  endtask

  task automatic test_random_stream();
    logic [31:0] w;
    int kind;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(9);
      case (kind)
        0, 1, 2: w = 32'h4000_0000 | ($urandom() & 32'h3FFF_FFFF);
        3, 4:    w = 32'h2800_0000 | ($urandom() & 32'h03FF_FFFF);
        5:       w = 32'h2C00_0000 | ($urandom() & 32'h03FF_FFFF);
        6:       w = 32'hE000_0000 | ($urandom() & 32'h0FFF_FFFF);
        7:       w = 32'hD000_0000 | (32'(m_frame) << 20) | ($urandom() & 32'h000F_FFFF);
        8:       w = 32'hD000_0000 | ($urandom() & 32'h0FFF_FFFF);
        default: do w = $urandom(); while (is_legal(w));
      endcase
      add_word(w);
    end
    run_words(60, 5000);
    n_total++; if (timeout !== 1'b0) begin n_bad++; $display("[TB] FAIL rnd_timeout got=%0b exp=0", timeout); end
    n_total++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL rnd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_total++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("[TB] FAIL rnd_sample%0d got=%0h exp=%0h", i, obs_q[i], exp_q[i]); end
    end
    n_total++; if (obs_fe != exp_fe) begin n_bad++; $display("[TB] FAIL rnd_fend got=%0d exp=%0d", obs_fe, exp_fe); end
    n_total++; if (obs_ferr != exp_ferr) begin n_bad++; $display("[TB] FAIL rnd_ferr got=%0d exp=%0d", obs_ferr, exp_ferr); end
    n_total++; if (obs_herr != exp_herr) begin n_bad++; $display("[TB] FAIL rnd_hdr got=%0d exp=%0d", obs_herr, exp_herr); end
    n_total++; if (int'(err_cnt) != m_err) begin n_bad++; $display("[TB] FAIL rnd_errcnt got=%0d exp=%0d", err_cnt, m_err); end
    n_total++; if (stall_viol != 0) begin n_bad++; $display("[TB] FAIL rnd_stall got=%0d exp=0", stall_viol); end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_baseline();
    test_signal_stall();
    test_frames();
    test_illegal_idle();
    test_reset_mid();
    test_err_saturate();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
